// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester RAM arbiter.
// Requester indices and lock-owner encodings used by ram_arb_rr and ram_arbiter.
package ram_arb_pkg;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_DMA  = 1;

  localparam logic [1:0] LOCK_NONE = 2'b00;
  localparam logic [1:0] LOCK_M0   = 2'b01;
  localparam logic [1:0] LOCK_M1   = 2'b10;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  // Index of a one-hot grant; only meaningful when the grant is non-zero.
  function automatic logic gnt_index(input logic [1:0] gnt);
    return gnt[REQ_DMA];
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin grant with last-winner and optional lock-owner state.
// Lock support is built only when RAM_ARB_LOCK_EN is defined.
import ram_arb_pkg::*;

module ram_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  logic last_gnt_q;
  logic last_gnt_d;

`ifdef RAM_ARB_LOCK_EN
  logic [1:0] lock_own_q;
  logic [1:0] lock_own_d;
  logic       lock_hold_s;

  // The owner only keeps priority while it is still requesting with lock high.
  assign lock_hold_s = |(lock_own_q & req_i & lock_i);
`else
  logic unused_lock_s;
  assign unused_lock_s = ^lock_i;
`endif

  // Grant selection: lock owner first, then round-robin on ties.
  always_comb begin
    gnt_o = GNT_NONE;
    if (rst) begin
      gnt_o = GNT_NONE;
`ifdef RAM_ARB_LOCK_EN
    end else if (lock_hold_s) begin
      gnt_o = lock_own_q;
`endif
    end else begin
      case (req_i)
        2'b01:   gnt_o = GNT_M0;
        2'b10:   gnt_o = GNT_M1;
        2'b11:   gnt_o = last_gnt_q ? GNT_M0 : GNT_M1;
        default: gnt_o = GNT_NONE;
      endcase
    end
  end

  // Next-state for the fairness and lock registers.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (|gnt_o) begin
      last_gnt_d = gnt_index(gnt_o);
    end else begin
      last_gnt_d = last_gnt_q;
    end
`ifdef RAM_ARB_LOCK_EN
    lock_own_d = lock_own_q;
    if ((lock_own_q != LOCK_NONE) && !lock_hold_s) begin
      lock_own_d = LOCK_NONE;
    end else begin
      lock_own_d = lock_own_q;
    end
    // A new lock request from this cycle's winner overrides a release.
    if (|(gnt_o & lock_i)) begin
      lock_own_d = gnt_o;
    end else begin
      lock_own_d = lock_own_d;
    end
`endif
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
`ifdef RAM_ARB_LOCK_EN
      lock_own_q <= LOCK_NONE;
`endif
    end else begin
      last_gnt_q <= last_gnt_d;
`ifdef RAM_ARB_LOCK_EN
      lock_own_q <= lock_own_d;
`endif
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous-read RAM (core = m0, loader/DMA = m1).
// Optional grant locking is enabled with the RAM_ARB_LOCK_EN macro.
import ram_arb_pkg::*;

module ram_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [1:0]    req_s;
  logic [1:0]    lock_s;
  logic [1:0]    gnt_s;
  logic [1:0]    rd_pend_q;
  logic [1:0]    rd_pend_d;
  logic [AW-1:0] addr_hold_q;
  logic [AW-1:0] addr_hold_d;

  assign req_s  = {m1_req, m0_req};
  assign lock_s = {m1_lock, m0_lock};

  ram_arb_rr u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_s),
    .lock_i (lock_s),
    .gnt_o  (gnt_s)
  );

  assign m0_gnt = gnt_s[REQ_CORE];
  assign m1_gnt = gnt_s[REQ_DMA];

  // RAM port mux; idle cycles replay the last address so ram_dout stays put.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_hold_q;
    ram_din  = {DW{1'b0}};
    case (gnt_s)
      GNT_M0: begin
        ram_we   = m0_we;
        ram_addr = m0_addr;
        ram_din  = m0_wdata;
      end
      GNT_M1: begin
        ram_we   = m1_we;
        ram_addr = m1_addr;
        ram_din  = m1_wdata;
      end
      default: begin
        ram_we   = 1'b0;
        ram_addr = addr_hold_q;
        ram_din  = {DW{1'b0}};
      end
    endcase
  end

  // Next-state for read-pending flags and the held address.
  always_comb begin
    rd_pend_d = gnt_s & ~{m1_we, m0_we};
    if (|gnt_s) begin
      addr_hold_d = ram_addr;
    end else begin
      addr_hold_d = addr_hold_q;
    end
  end

  // Read-return and address-hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q   <= 2'b00;
      addr_hold_q <= {AW{1'b0}};
    end else begin
      rd_pend_q   <= rd_pend_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  // Synchronous-read data arrives the cycle after the grant, matching rd_pend.
  assign m0_rvalid = rd_pend_q[REQ_CORE];
  assign m1_rvalid = rd_pend_q[REQ_DMA];
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table plus hand-written corner sequences,
// read data checked through per-requester scoreboard queues against a shadow memory.
module tb_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] sh_mem [0:(1<<AW)-1];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [AW-1:0] hold_addr = '0;

  typedef struct {
    logic          rs;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          l0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          l1;
    logic [1:0]    g;
  } vec_t;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read RAM model.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rs, input logic r0, input logic w0,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic l0,
                              input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic l1,
                              input logic [1:0] g);
    vec_t v;
    v.rs = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.l1 = l1; v.g = g;
    return v;
  endfunction

  function automatic vec_t idle(input logic rs);
    return mk(rs, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'b00);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Compare registered read-return outputs against the scoreboard queues.
  task automatic chk_rv(input string nm);
    logic          e0, e1;
    logic [DW-1:0] d;
    e0 = (q0.size() > 0);
    e1 = (q1.size() > 0);
    chk({nm, "/m0_rvalid"}, 32'(m0_rvalid), 32'(e0));
    chk({nm, "/m1_rvalid"}, 32'(m1_rvalid), 32'(e1));
    if (e0) begin
      d = q0.pop_front();
      if (m0_rvalid) chk({nm, "/m0_rdata"}, 32'(m0_rdata), 32'(d));
    end
    if (e1) begin
      d = q1.pop_front();
      if (m1_rvalid) chk({nm, "/m1_rdata"}, 32'(m1_rdata), 32'(d));
    end
  endtask

  // One cycle: check returns, drive a vector, check grant and RAM port, update model.
  task automatic step(input vec_t v, input string nm);
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    chk_rv(nm);
    rst = v.rs;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0; m0_lock = v.l0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.l1;
    if (v.rs) begin
      q0.delete();
      q1.delete();
      hold_addr = '0;
    end
    #1;
    chk({nm, "/gnt"}, 32'({m1_gnt, m0_gnt}), 32'(v.g));
    ew = 1'b0; ea = hold_addr; ed = '0;
    if (v.g == 2'b01) begin
      ew = v.w0; ea = v.a0; ed = v.d0;
      if (v.w0) sh_mem[v.a0] = v.d0; else q0.push_back(sh_mem[v.a0]);
    end else if (v.g == 2'b10) begin
      ew = v.w1; ea = v.a1; ed = v.w1 ? v.d1 : v.d1;
      if (v.w1) sh_mem[v.a1] = v.d1; else q1.push_back(sh_mem[v.a1]);
    end
    hold_addr = ea;
    chk({nm, "/ram_we"},   32'(ram_we),   32'(ew));
    chk({nm, "/ram_addr"}, 32'(ram_addr), 32'(ea));
    chk({nm, "/ram_din"},  32'(ram_din),  32'(ed));
  endtask

  initial begin
    vec_t tab[$];
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    #1 rst = 1'b1;

    // Reset: requests ignored, no write strobe.
    tab.push_back(mk(1'b1, 1'b1, 1'b1, 13'h001, 16'h1234, 1'b0, 1'b1, 1'b1, 13'h002, 16'h5678, 1'b0, 2'b00));
    tab.push_back(mk(1'b1, 1'b1, 1'b1, 13'h001, 16'h1234, 1'b0, 1'b1, 1'b1, 13'h002, 16'h5678, 1'b0, 2'b00));
    // Loader preload through m1.
    tab.push_back(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b1, 13'h010, 16'h1111, 1'b0, 2'b10));
    tab.push_back(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b1, 13'h011, 16'h2222, 1'b0, 2'b10));
    tab.push_back(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b1, 13'h030, 16'h3333, 1'b0, 2'b10));
    tab.push_back(idle(1'b1));
    // m0 write vs m1 read of same address right after reset.
    tab.push_back(mk(1'b0, 1'b1, 1'b1, 13'h020, 16'hA5A5, 1'b0, 1'b1, 1'b0, 13'h020, 16'h0000, 1'b0, 2'b01));
    tab.push_back(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h020, 16'h0000, 1'b0, 2'b10));
    tab.push_back(idle(1'b0));
    // Both requesting reads every cycle: grants alternate.
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(1'b0, 1'b1, 1'b0, 13'h010, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b0,
                       (i % 2 == 0) ? 2'b01 : 2'b10));
    tab.push_back(idle(1'b0));
    // Write then read-back on m0.
    tab.push_back(mk(1'b0, 1'b1, 1'b1, 13'h005, 16'hBEEF, 1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 2'b01));
    tab.push_back(mk(1'b0, 1'b1, 1'b0, 13'h005, 16'h0000, 1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 2'b01));
    tab.push_back(idle(1'b0));
    // Read of 0x030 before the idle-hold sequence.
    tab.push_back(mk(1'b0, 1'b1, 1'b0, 13'h030, 16'h0000, 1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 2'b01));

    foreach (tab[i]) step(tab[i], $sformatf("v%0d", i));

    // Idle cycles keep the address so RAM output holds the last read.
    for (int i = 0; i < 3; i++) begin
      step(idle(1'b0), $sformatf("hold%0d", i));
      chk($sformatf("hold%0d/ram_dout", i), 32'(ram_dout), 32'h0000_3333);
    end

    // Reset asserted while a read return is pending.
    step(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h030, 16'h0000, 1'b0, 2'b10), "mid");
    @(posedge clk);
    #1 rst = 1'b1;
    q0.delete();
    q1.delete();
    hold_addr = '0;
    step(mk(1'b1, 1'b1, 1'b0, 13'h010, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b0, 2'b00), "rst_mid");
    step(mk(1'b0, 1'b1, 1'b0, 13'h010, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b0, 2'b01), "post_rst0");
    step(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b0, 2'b10), "post_rst1");
    step(idle(1'b0), "post_rst2");

`ifdef RAM_ARB_LOCK_EN
    // m1 holds the RAM with lock; m0 waits until the lock drops.
    step(mk(1'b0, 1'b1, 1'b0, 13'h010, 16'h0000, 1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 2'b01), "lk_pre");
    for (int i = 0; i < 4; i++)
      step(mk(1'b0, 1'b1, 1'b0, 13'h010, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b1, 2'b10),
           $sformatf("lk%0d", i));
    step(mk(1'b0, 1'b1, 1'b0, 13'h010, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b0, 2'b01), "lk_drop");
    step(mk(1'b0, 1'b0, 1'b0, 13'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 13'h011, 16'h0000, 1'b0, 2'b10), "lk_after");
`endif

    step(idle(1'b0), "drain0");
    step(idle(1'b0), "drain1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter sharing the single-port, synchronous-read data RAM (DW=16, AW=13).
- Requester 0 is the core data port; requester 1 is the loader/DMA port.
- Same-cycle combinational grant, round-robin fairness, read-data return one cycle after a granted read.
- Holds the RAM address while idle so RAM read data stays stable.

Parameters:
DW, 16, data width of RAM and requester ports
AW, 13, address width of RAM and requester ports

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
m0_req  input  1  requester 0 access request
m0_we  input  1  requester 0 write (1) / read (0)
m0_addr  input  AW  requester 0 address
m0_wdata  input  DW  requester 0 write data
m0_lock  input  1  requester 0 hold grant (only with RAM_ARB_LOCK_EN)
m0_gnt  output  1  requester 0 granted this cycle
m0_rvalid  output  1  requester 0 read data valid
m0_rdata  output  DW  requester 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, requester 1
ram_we  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_din  output  DW  RAM write data
ram_dout  input  DW  RAM read data

Behaviour:
- State registers:
  - last_gnt: 1 bit, reset 1, so m0 wins the first tie.
  - lock_own: 2 bits, one-hot owner or 00, reset 00.
  - rd_pend: 2 bits, reset 00.
  - addr_hold: AW bits, reset 0.
- All state resets asynchronously on rst. While rst=1: both gnt=0, ram_we=0, both rvalid=0.
- Grant (combinational, at most one per cycle):
  - Only one req: that requester is granted.
  - Both req: grant the one NOT equal to last_gnt.
  - Neither req: no grant.
- last_gnt <= index of the granted requester on every grant cycle. Unchanged when idle.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen high. The transfer completes in the gnt cycle.
- RAM drive:
  - Grant cycle: ram_addr/ram_din/ram_we come from the granted requester.
  - Idle cycle: ram_addr=addr_hold, ram_we=0, ram_din=0.
  - addr_hold <= ram_addr on every grant.
- Read return:
  - Granted read (we=0) sets rd_pend[i] for the next cycle only.
  - mi_rvalid = rd_pend[i]; mi_rdata = ram_dout, valid only while rvalid=1.
  - Latency is exactly 1 cycle after gnt. Back-to-back reads give rvalid on consecutive cycles.
- Writes produce no rvalid.
- Read-after-write to the same address on the next grant returns the new data.
- Simultaneous write by m0 and read by m1: only one is granted; the loser keeps req high and is granted next cycle (round-robin guarantees at most 1 wait cycle).
- Reset mid-read: rd_pend clears; the pending rvalid is dropped.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- Defined:
  - If the granted requester has lock=1 in its grant cycle, lock_own <= that requester.
  - While lock_own=i, mi_req=1 always wins and the other requester waits.
  - Lock releases (lock_own <= 00) on the first cycle with mi_req=0 or mi_lock=0 on the owner.
  - last_gnt updates normally.
- Undefined: m0_lock/m1_lock are ignored, lock_own is not built, arbitration is pure round-robin. Ports remain present.

Decomposition:
- Package ram_arb_pkg:
  - requester index constants REQ_CORE=0, REQ_DMA=1.
  - lock_own encoding constants LOCK_NONE=2'b00, LOCK_M0=2'b01, LOCK_M1=2'b10.
- Sub-module ram_arb_rr: 2-way round-robin grant logic plus last_gnt/lock_own registers. Inputs: reqs, locks. Output: one-hot grant.
- The top module handles the RAM mux, addr_hold and rd_pend.

Test Plan:
- Reset then m0 write addr 0x005 data 0xBEEF, next cycle m0 read 0x005 -> m0_gnt=1 both cycles, m0_rvalid=1 one cycle after the read gnt with m0_rdata=0xBEEF, m1_rvalid=0.
- Both req every cycle (m0 reads 0x010, m1 reads 0x011, preloaded 0x1111/0x2222) -> gnt alternates m0,m1,m0,...; each rvalid follows its own gnt by 1 cycle with the correct data.
- m0 write 0x020=0xA5A5 and m1 read 0x020 asserted the same cycle after reset -> m0 granted first; m1 granted next cycle and reads 0xA5A5.
- Granted read of 0x030 followed by 3 idle cycles -> ram_addr stays 0x030, ram_we=0, ram_dout stable.
- rst asserted asynchronously one cycle after a granted read -> rvalid never asserts; after release, a tie grants m0 first.
- RAM_ARB_LOCK_EN defined: m1 req+lock for 4 cycles with m0 req held -> m1 granted 4 consecutive cycles; m0 granted on the cycle m1 drops lock.
